// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: stall, flush and forward control.
// Tracks register numbers D->E->M->W with valid tags and counts stall/flush cycles.
module hazard_unit #(
   parameter int REG_BITS = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [REG_BITS-1:0] RA1D,
   input  logic [REG_BITS-1:0] RA2D,
   input  logic [REG_BITS-1:0] WA3D,
   input  logic                RegWriteM,
   input  logic                RegWriteW,
   input  logic                MemtoRegE,
   input  logic                PCSrcD,
   input  logic                PCSrcE,
   input  logic                PCSrcM,
   input  logic                PCSrcW,
   input  logic                BranchTakenE,
   output logic [1:0]          ForwardAE,
   output logic [1:0]          ForwardBE,
   output logic                StallF,
   output logic                StallD,
   output logic                FlushD,
   output logic                FlushE,
   output logic [CNT_W-1:0]    StallCnt,
   output logic [CNT_W-1:0]    FlushCnt
);

   localparam logic [REG_BITS-1:0] PC_REG = '1;

   logic [REG_BITS-1:0] ra1_e_q, ra1_e_d;
   logic [REG_BITS-1:0] ra2_e_q, ra2_e_d;
   logic [REG_BITS-1:0] wa3_e_q, wa3_e_d;
   logic [REG_BITS-1:0] wa3_m_q, wa3_m_d;
   logic [REG_BITS-1:0] wa3_w_q, wa3_w_d;
   logic                ve_q, ve_d;
   logic                vm_q, vm_d;
   logic                vw_q, vw_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

   logic       ldr_stall;
   logic       pc_wr_pend;
   logic       stall_f;
   logic       stall_d;
   logic       flush_d;
   logic       flush_e;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] ra);
      logic [1:0] sel;
      sel = 2'b00;
      if (ve_q && (ra != PC_REG)) begin
         if (vm_q && RegWriteM && (ra == wa3_m_q))
            sel = 2'b10;
         else if (vw_q && RegWriteW && (ra == wa3_w_q))
            sel = 2'b01;
      end
      return sel;
   endfunction

   // Hazard detection and forwarding selects from tracked pipeline state.
   always_comb begin
      ldr_stall  = ve_q && MemtoRegE &&
                   ((RA1D == wa3_e_q) || (RA2D == wa3_e_q));
      pc_wr_pend = PCSrcD || PCSrcE || PCSrcM;
      stall_f    = ldr_stall || pc_wr_pend;
      stall_d    = ldr_stall;
      flush_d    = pc_wr_pend || PCSrcW || BranchTakenE;
      flush_e    = ldr_stall || BranchTakenE;
      fwd_a      = fwd_sel(ra1_e_q);
      fwd_b      = fwd_sel(ra2_e_q);
   end

   // Next-state: advance register tags, bubble E on flush, saturating counters.
   always_comb begin
      ra1_e_d     = ra1_e_q;
      ra2_e_d     = ra2_e_q;
      wa3_e_d     = wa3_e_q;
      ve_d        = 1'b0;
      wa3_m_d     = wa3_e_q;
      vm_d        = ve_q;
      wa3_w_d     = wa3_m_q;
      vw_d        = vm_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!flush_e) begin
         ra1_e_d = RA1D;
         ra2_e_d = RA2D;
         wa3_e_d = WA3D;
         ve_d    = 1'b1;
      end
      if (stall_d && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_e && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ra1_e_q     <= '0;
         ra2_e_q     <= '0;
         wa3_e_q     <= '0;
         ve_q        <= 1'b0;
         wa3_m_q     <= '0;
         vm_q        <= 1'b0;
         wa3_w_q     <= '0;
         vw_q        <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ra1_e_q     <= ra1_e_d;
         ra2_e_q     <= ra2_e_d;
         wa3_e_q     <= wa3_e_d;
         ve_q        <= ve_d;
         wa3_m_q     <= wa3_m_d;
         vm_q        <= vm_d;
         wa3_w_q     <= wa3_w_d;
         vw_q        <= vw_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Outputs are held low for as long as reset is asserted.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      StallCnt  = '0;
      FlushCnt  = '0;
      if (reset) begin
         ForwardAE = fwd_a;
         ForwardBE = fwd_b;
         StallF    = stall_f;
         StallD    = stall_d;
         FlushD    = flush_d;
         FlushE    = flush_e;
         StallCnt  = stall_cnt_q;
         FlushCnt  = flush_cnt_q;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver pushes model predictions,
// negedge monitor pops and compares against the DUT outputs.
module tb_hazard_unit;

   localparam int RB = 4;
   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic [RB-1:0] RA1D, RA2D, WA3D;
   logic          RegWriteM, RegWriteW, MemtoRegE;
   logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
   logic [1:0]    ForwardAE, ForwardBE;
   logic          StallF, StallD, FlushD, FlushE;
   logic [CW-1:0] StallCnt, FlushCnt;

   hazard_unit #(.REG_BITS(RB), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
      .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .FlushE(FlushE),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: three in-flight instruction slots (E, M, W).
   typedef struct {
      bit          v;
      logic [3:0]  ra1;
      logic [3:0]  ra2;
      logic [3:0]  wa;
   } slot_t;

   typedef struct {
      logic [15:0] bits;
      int          cyc;
   } exp_t;

   slot_t se, sm, sw;
   int    scnt, fcnt;
   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;
   int    ncyc   = 0;

   function automatic logic [1:0] mfwd(input logic [3:0] ra,
                                       input bit rwm, input bit rww);
      if (!se.v || ra == 4'd15) return 2'b00;
      if (sm.v && rwm && ra == sm.wa) return 2'b10;
      if (sw.v && rww && ra == sw.wa) return 2'b01;
      return 2'b00;
   endfunction

   task automatic cyc(input bit r,
                      input logic [3:0] a1, input logic [3:0] a2,
                      input logic [3:0] w,
                      input bit rwm, input bit rww, input bit mte,
                      input bit pd, input bit pe, input bit pm,
                      input bit pw, input bit bt);
      bit   ldr, pend, fe, sd;
      exp_t e;
      reset = r; RA1D = a1; RA2D = a2; WA3D = w;
      RegWriteM = rwm; RegWriteW = rww; MemtoRegE = mte;
      PCSrcD = pd; PCSrcE = pe; PCSrcM = pm; PCSrcW = pw;
      BranchTakenE = bt;
      ldr  = se.v && mte && (a1 == se.wa || a2 == se.wa);
      pend = pd || pe || pm;
      sd   = ldr;
      fe   = ldr || bt;
      e.cyc = ncyc;
      if (!r)
         e.bits = 16'h0;
      else
         e.bits = {mfwd(se.ra1, rwm, rww), mfwd(se.ra2, rwm, rww),
                   ldr || pend, sd, pend || pw || bt, fe,
                   scnt[3:0], fcnt[3:0]};
      sb.push_back(e);
      @(posedge clk);
      if (!r) begin
         se.v = 0; sm.v = 0; sw.v = 0;
         scnt = 0; fcnt = 0;
      end else begin
         sw = sm;
         sm = se;
         if (fe) se.v = 0;
         else begin
            se.v = 1; se.ra1 = a1; se.ra2 = a2; se.wa = w;
         end
         if (sd && scnt < 15) scnt++;
         if (fe && fcnt < 15) fcnt++;
      end
      ncyc++;
      #1;
   endtask

   task automatic idle(input bit r);
      cyc(r, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [3:0] rr();
      if ($urandom_range(0, 7) == 0) return 4'd15;
      return 4'($urandom_range(0, 3));
   endfunction

   // Monitor: compare every presented output vector with the queued prediction.
   always @(negedge clk) begin
      exp_t e;
      logic [15:0] act;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         act = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
                StallCnt, FlushCnt};
         checks++;
         if (act !== e.bits) begin
            errors++;
            $display("FAIL cycle%0d outputs: got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b sc=%0d fc=%0d, expected fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b sc=%0d fc=%0d",
                     e.cyc, act[15:14], act[13:12], act[11], act[10],
                     act[9], act[8], act[7:4], act[3:0],
                     e.bits[15:14], e.bits[13:12], e.bits[11],
                     e.bits[10], e.bits[9], e.bits[8],
                     e.bits[7:4], e.bits[3:0]);
         end
      end
   end

   initial begin
      int guard;
      se = '{default: '0}; sm = se; sw = se;
      scnt = 0; fcnt = 0;
      reset = 0; RA1D = 0; RA2D = 0; WA3D = 0;
      RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
      PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
      @(posedge clk);
      #1;
      // reset with random inputs
      for (int i = 0; i < 2; i++)
         cyc(0, rr(), rr(), rr(), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));
      idle(1);
      idle(1);
      // ADD R1; SUB R4,R1,R3; instr reading R1 -> forward M then W
      cyc(1, 4'd0, 4'd0, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 4'd1, 4'd3, 4'd4, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 4'd1, 4'd0, 4'd5, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, 0, 0, 0, 0);
      idle(1);
      // load-use on R2
      cyc(1, 4'd0, 4'd0, 4'd2, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 4'd0, 4'd2, 4'd3, 0, 0, 1, 0, 0, 0, 0, 0);
      cyc(1, 4'd0, 4'd2, 4'd3, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      // PC write walking D,E,M,W
      cyc(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
      cyc(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(1);
      // load-use coinciding with taken branch, then bubble in E
      cyc(1, 4'd0, 4'd0, 4'd6, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 4'd6, 4'd0, 4'd7, 0, 0, 1, 0, 0, 0, 0, 1);
      cyc(1, 4'd6, 4'd6, 4'd0, 1, 1, 0, 0, 0, 0, 0, 0);
      idle(1);
      // repeated load-use to saturate the stall counter
      for (int i = 0; i < 40; i++)
         cyc(1, 4'd8, 4'd8, 4'd8, 0, 0, 1, 0, 0, 0, 0, 0);
      // R15 reads never forward
      cyc(1, 4'd0, 4'd0, 4'd15, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 4'd15, 4'd15, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, 0, 0, 0, 0);
      // reset mid-operation then release
      cyc(1, 4'd3, 4'd3, 4'd3, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 4'd3, 4'd3, 4'd3, 1, 1, 1, 0, 0, 0, 0, 0);
      cyc(1, 4'd3, 4'd3, 4'd3, 1, 1, 1, 0, 0, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 400; i++)
         cyc(($urandom_range(0, 49) != 0), rr(), rr(), rr(),
             1'($urandom), 1'($urandom),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 7) == 0));
      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d pending, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
